// File: rtl/bnn_pool2x2.sv
// 2x2 stride-2 binary max-pooling stage: reads square feature-map rows from the conv
// output SRAM and writes header + pooled rows. Define BNN_POOL_MAJORITY_EN for threshold pooling.
module bnn_pool2x2 #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              wr_enable
);

  localparam logic [3:0] S_IDLE = 4'd0,
                         S_HA   = 4'd1,
                         S_HW8  = 4'd2,
                         S_HWR  = 4'd3,
                         S_RA   = 4'd4,
                         S_RB   = 4'd5,
                         S_CAP  = 4'd6,
                         S_WR   = 4'd7,
                         S_DONE = 4'd8;

  localparam int unsigned HALF_W = DATA_W / 2;

  logic [3:0]        state;
  logic [3:0]        half;
  logic              n_ok;
  logic [3:0]        r;
  logic [DATA_W-1:0] row_a;
  logic [DATA_W-1:0] row_b;
  logic [DATA_W-1:0] pool;
  logic [3:0]        win;

  logic       hdr_hi;
  logic [4:0] hdr_n;
  logic       hdr_ok;

  assign hdr_hi = |sram_dut_read_data[DATA_W-1:5];
  assign hdr_n  = sram_dut_read_data[4:0];
  assign hdr_ok = !hdr_hi && (hdr_n != 5'd0) && !hdr_n[0] && (hdr_n <= 5'd16);

  // Columns at or beyond N/2 are forced to 0 so stray high input bits never leak out.
  always_comb begin
    pool = '0;
    win  = '0;
    for (int unsigned j = 0; j < HALF_W; j++) begin
      win = {row_a[2*j], row_a[2*j+1], row_b[2*j], row_b[2*j+1]};
      if (j < 32'(half)) begin
`ifdef BNN_POOL_MAJORITY_EN
        pool[j] = (win[3] & win[2]) | (win[3] & win[1]) | (win[3] & win[0]) |
                  (win[2] & win[1]) | (win[2] & win[0]) | (win[1] & win[0]);
`else
        pool[j] = |win;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= S_IDLE;
      half                   <= '0;
      n_ok                   <= 1'b0;
      r                      <= '0;
      row_a                  <= '0;
      row_b                  <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
      err                    <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      wr_enable              <= 1'b0;
    end else begin
      wr_enable <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            err   <= 1'b0;
            state <= S_HA;
          end
        end
        S_HA: begin
          busy                  <= 1'b1;
          dut_sram_read_address <= ADDR_W'(IN_BASE);
          state                 <= S_HW8;
        end
        S_HW8: begin
          n_ok <= hdr_ok;
          if (!hdr_hi) half <= hdr_n[4:1];
          state <= S_HWR;
        end
        S_HWR: begin
          wr_enable              <= 1'b1;
          dut_sram_write_address <= ADDR_W'(OUT_BASE);
          r                      <= '0;
          if (n_ok) begin
            dut_sram_write_data <= DATA_W'(half);
            state               <= S_RA;
          end else begin
            dut_sram_write_data <= '0;
            err                 <= 1'b1;
            state               <= S_DONE;
          end
        end
        S_RA: begin
          dut_sram_read_address <= ADDR_W'(IN_BASE + 1) + ADDR_W'({r, 1'b0});
          state                 <= S_RB;
        end
        S_RB: begin
          dut_sram_read_address <= ADDR_W'(IN_BASE + 2) + ADDR_W'({r, 1'b0});
          row_a                 <= sram_dut_read_data;
          state                 <= S_CAP;
        end
        S_CAP: begin
          row_b <= sram_dut_read_data;
          state <= S_WR;
        end
        S_WR: begin
          wr_enable              <= 1'b1;
          dut_sram_write_address <= ADDR_W'(OUT_BASE + 1) + ADDR_W'(r);
          dut_sram_write_data    <= pool;
          r                      <= r + 4'd1;
          state                  <= (r + 4'd1 == half) ? S_DONE : S_RA;
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
